// File: rtl/imem_loader.sv
// Instruction-memory program loader: framed byte stream in, one 32-bit write per word out.
// Holds the CPU in reset until a complete image with a matching checksum has been written.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | hunting for SYNC_BYTE, other bytes discarded
// S_LEN_HI | next byte is N[15:8]
// S_LEN_LO | next byte is N[7:0], length is range-checked
// S_DATA   | assembling big-endian words, one memory write per word
// S_CSUM   | next byte is compared with the running data checksum
// S_DONE   | image verified, CPU released, no further bytes accepted
// S_ERR    | framing/length/checksum failure, hunting for SYNC_BYTE
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter int          MAX_WORDS = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [23:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [7:0]        acc_q, acc_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              accept;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   words_inc;

  assign accept    = rx_valid && rx_ready;
  assign len_full  = {len_q[15:8], rx_data};
  assign words_inc = words_q + {{ADDR_W{1'b0}}, 1'b1};

  assign rx_ready     = (state_q != S_DONE);
  assign cpu_hold     = (state_q != S_DONE);
  assign load_done    = (state_q == S_DONE);
  assign load_err     = (state_q == S_ERR);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign words_loaded = words_q;

  // Next-state and datapath update; everything advances only on an accepted byte.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    words_d     = words_q;
    acc_d       = acc_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (accept) begin
      unique case (state_q)
        S_IDLE, S_ERR: begin
          if (rx_data == SYNC_BYTE) begin
            state_d    = S_LEN_HI;
            acc_d      = 8'h00;
            words_d    = '0;
            byte_cnt_d = 2'd0;
          end
        end
        S_LEN_HI: begin
          len_d   = {rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d = len_full;
          if (len_full == 16'h0000 || {1'b0, len_full} > MAX_N) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          word_d     = {word_q[15:0], rx_data};
          acc_d      = acc_q + rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Word index stays below N <= 2**ADDR_W, so the low ADDR_W bits are exact.
            mem_we_d    = 1'b1;
            mem_wdata_d = {word_q, rx_data};
            mem_addr_d  = {{(30 - ADDR_W){1'b0}}, words_q[ADDR_W-1:0], 2'b00};
            words_d     = words_inc;
            if ({{(15 - ADDR_W){1'b0}}, words_inc} == len_q) begin
              state_d = S_CSUM;
            end
          end
        end
        S_CSUM: begin
          state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= 16'h0000;
      word_q      <= 24'h000000;
      byte_cnt_q  <= 2'd0;
      words_q     <= '0;
      acc_q       <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      byte_cnt_q  <= byte_cnt_d;
      words_q     <= words_d;
      acc_q       <= acc_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-position reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [10:0] words_loaded;

  imem_loader #(.ADDR_W(10), .MAX_WORDS(1024), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [63:0] wq[$];
  logic [7:0]  frame[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks position inside the frame rather than a state machine.
  bit          m_hunt, m_done, m_err, m_we;
  int          m_pos, m_n, m_acc, m_words;
  logic [31:0] m_word, m_addr, m_wdata;

  function automatic void m_reset();
    m_hunt = 1; m_done = 0; m_err = 0; m_we = 0;
    m_pos = 0; m_n = 0; m_acc = 0; m_words = 0;
    m_word = 0; m_addr = 0; m_wdata = 0;
  endfunction

  function automatic void m_step(input logic [7:0] b);
    int k;
    if (m_hunt) begin
      if (b == 8'hA5) begin
        m_hunt = 0; m_err = 0; m_pos = 1; m_words = 0; m_acc = 0;
      end
    end else if (m_pos == 1) begin
      m_n = int'(b) * 256; m_pos = 2;
    end else if (m_pos == 2) begin
      m_n = m_n + int'(b);
      if (m_n == 0 || m_n > 1024) begin
        m_err = 1; m_hunt = 1;
      end else begin
        m_pos = 3;
      end
    end else if (m_pos < 3 + 4 * m_n) begin
      k = m_pos - 3;
      m_word = {m_word[23:0], b};
      m_acc = (m_acc + int'(b)) % 256;
      if (k % 4 == 3) begin
        m_we = 1; m_addr = 32'((k / 4) * 4); m_wdata = m_word; m_words++;
      end
      m_pos++;
    end else begin
      if (b == m_acc[7:0]) m_done = 1;
      else begin m_err = 1; m_hunt = 1; end
    end
  endfunction

  // Every-cycle compare against the model, then advance the model by the byte
  // that the coming rising edge will transfer.
  always @(negedge clk) begin
    if (!reset) m_reset();
    chk("rx_ready", 64'(rx_ready), 64'(!m_done));
    chk("mem_we", 64'(mem_we), 64'(m_we));
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("cpu_hold", 64'(cpu_hold), 64'(!m_done));
    chk("load_done", 64'(load_done), 64'(m_done));
    chk("load_err", 64'(load_err), 64'(m_err));
    chk("words_loaded", 64'(words_loaded), 64'(m_words));
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
    if (reset) begin
      m_we = 0;
      if (rx_valid && !m_done) m_step(rx_data);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    rx_valid = 1'b0;
    repeat (gap) begin rx_data = 8'($urandom); @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (rx_ready) begin @(posedge clk); #1; break; end
      budget++;
      if (budget > 20) begin
        total++; bad++;
        $display("FAIL accept_timeout: byte %0h not taken within 20 cycles", b);
        @(posedge clk); #1;
        break;
      end
    end
  endtask

  task automatic send_frame(input int gapmax);
    foreach (frame[i]) send_byte(frame[i], int'($urandom_range(0, gapmax)));
    rx_valid = 1'b0;
  endtask

  task automatic build(input int n, input bit corrupt);
    logic [7:0] s, d;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n >> 8));
    frame.push_back(8'(n));
    s = 8'h00;
    for (int i = 0; i < 4 * n; i++) begin
      d = 8'($urandom);
      frame.push_back(d);
      s = s + d;
    end
    if (corrupt) s = s + 8'd1;
    frame.push_back(s);
  endtask

  task automatic build_t1();
    logic [7:0] s;
    frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h22, 8'h18, 8'h24, 8'h00, 8'h22, 8'h20, 8'h25};
    s = 8'h00;
    for (int i = 3; i < 11; i++) s = s + frame[i];
    frame.push_back(s);
  endtask

  task automatic pulse_reset();
    rx_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wq.delete();
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) begin rx_data = 8'($urandom); @(posedge clk); #1; end
  endtask

  task automatic check_t1(input string tag);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'd2);
    chk({tag, "_w0"}, wq[0], {32'h0000_0000, 32'h0022_1824});
    chk({tag, "_w1"}, wq[1], {32'h0000_0004, 32'h0022_2025});
    chk({tag, "_done"}, 64'(load_done), 64'd1);
    chk({tag, "_hold"}, 64'(cpu_hold), 64'd0);
    chk({tag, "_wl"}, 64'(words_loaded), 64'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    bit corrupt;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    chk("rst_ready", 64'(rx_ready), 64'd1);
    chk("rst_wl", 64'(words_loaded), 64'd0);
    reset = 1'b1;
    wq.delete();

    // 1: reference frame back-to-back
    build_t1();
    send_frame(0);
    check_t1("t1");

    // 2: same frame with valid gaps
    pulse_reset();
    build_t1();
    send_frame(3);
    check_t1("t2");
    idle(5);
    chk("t2_stays_done", 64'(load_done), 64'd1);

    // 3: garbage then a 1-word frame
    pulse_reset();
    send_byte(8'h00, 0); send_byte(8'hFF, 1); send_byte(8'h12, 0);
    build(1, 0);
    send_frame(2);
    chk("t3_nwr", 64'(wq.size()), 64'd1);
    chk("t3_done", 64'(load_done), 64'd1);

    // 4: zero and oversize lengths
    pulse_reset();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    idle(3);
    chk("t4_zero_err", 64'(load_err), 64'd1);
    send_byte(8'hA5, 0);
    chk("t4_sync_clears_err", 64'(load_err), 64'd0);
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    idle(3);
    chk("t4_big_err", 64'(load_err), 64'd1);
    chk("t4_nwr", 64'(wq.size()), 64'd0);
    chk("t4_hold", 64'(cpu_hold), 64'd1);

    // 5: bad checksum, then a good re-send
    pulse_reset();
    build(1, 1);
    send_frame(1);
    chk("t5_nwr", 64'(wq.size()), 64'd1);
    chk("t5_err", 64'(load_err), 64'd1);
    chk("t5_hold", 64'(cpu_hold), 64'd1);
    build(1, 0);
    send_frame(1);
    chk("t5_err_clr", 64'(load_err), 64'd0);
    chk("t5_done", 64'(load_done), 64'd1);

    // 6: reset mid-frame, then a full frame
    pulse_reset();
    build(2, 0);
    for (int i = 0; i < 9; i++) send_byte(frame[i], 0);
    rx_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_async_hold", 64'(cpu_hold), 64'd1);
    chk("t6_async_wl", 64'(words_loaded), 64'd0);
    chk("t6_async_addr", 64'(mem_addr), 64'd0);
    chk("t6_async_ready", 64'(rx_ready), 64'd1);
    @(posedge clk); #1 reset = 1'b1;
    wq.delete();
    build(2, 0);
    send_frame(0);
    chk("t6_done", 64'(load_done), 64'd1);
    chk("t6_nwr", 64'(wq.size()), 64'd2);

    // largest accepted image
    pulse_reset();
    build(1024, 0);
    send_frame(0);
    chk("max_done", 64'(load_done), 64'd1);
    chk("max_wl", 64'(words_loaded), 64'd1024);
    chk("max_last_addr", 64'(wq[1023][63:32]), 64'h0000_0FFC);

    // randomized frames
    for (int it = 0; it < 25; it++) begin
      pulse_reset();
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        send_byte(g, int'($urandom_range(0, 2)));
      end
      n = int'($urandom_range(1, 6));
      corrupt = ($urandom_range(0, 3) == 0);
      build(n, corrupt);
      send_frame(int'($urandom_range(0, 3)));
      idle(int'($urandom_range(1, 4)));
      chk("rnd_done", 64'(load_done), 64'(!corrupt));
      chk("rnd_err", 64'(load_err), 64'(corrupt));
      chk("rnd_nwr", 64'(wq.size()), 64'(n));
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
